// File: rtl/fourrom_ctrl.sv
// Four-socket EEPROM ROM board controller for the CPC bus: ROM select register,
// upper-ROM read decode, and a key-unlocked EEPROM programming window.
module fourrom_ctrl #(
    parameter int PROG_BUSY_CYCLES = 40000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] dip,
    input  logic [2:0] A,
    input  logic [7:0] D,
    input  logic       MREQ_B,
    input  logic       IOREQ_B,
    input  logic       RD_B,
    input  logic       WR_B,
    input  logic       ROMEN_B,
    output logic       rom01cs_b,
    output logic       rom23cs_b,
    output logic       roma14,
    output logic       romoe_b,
    output logic       romdis_pre,
    output logic       skt01p27,
    output logic       skt23p27,
    output logic       prog_busy
);
    typedef enum logic [1:0] {IDLE, KEY1, ARMED, BUSY} state_t;

    localparam logic [15:0] BUSY_LOAD = 16'(PROG_BUSY_CYCLES - 1);

    logic        a15, a14, a13;
    logic        iowr, memwr, iowr_q, commit, commit_zero;
    logic [7:0]  hold, romsel;
    logic [1:0]  idx;
    logic        hit, rd, web;
    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic        wr_seen, wr_seen_d;
    logic        lock_pend, lock_pend_d;

    assign a15 = A[2];
    assign a14 = A[1];
    assign a13 = A[0];

    assign iowr        = ~IOREQ_B & ~WR_B & ~a13;
    assign memwr       = ~MREQ_B & ~WR_B & a15 & a14;
    assign commit      = iowr_q & ~iowr;
    assign commit_zero = commit & (hold == 8'h00);

    // Select register: D is held while the IO write lasts and committed when it ends.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold   <= 8'h00;
            iowr_q <= 1'b0;
            romsel <= 8'h00;
        end else begin
            iowr_q <= iowr;
            if (iowr)   hold   <= D;
            if (commit) romsel <= hold;
        end
    end

    assign hit = dip[6] & (romsel[7:2] == dip[5:0]);
    assign idx = romsel[1:0];
    assign rd  = hit & ~ROMEN_B & ~RD_B & a15 & a14;
    // A concurrent read always wins, so the write enable can never overlap a read.
    assign web = (state == ARMED) & hit & memwr & ~rd;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            wr_seen   <= 1'b0;
            lock_pend <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            wr_seen   <= wr_seen_d;
            lock_pend <= lock_pend_d;
        end
    end

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        wr_seen_d   = wr_seen;
        lock_pend_d = lock_pend;
        if (!dip[7]) begin
            state_d     = IDLE;
            cnt_d       = 16'd0;
            wr_seen_d   = 1'b0;
            lock_pend_d = 1'b0;
        end else begin
            case (state)
                IDLE: if (commit && hold == 8'hA5) state_d = KEY1;
                KEY1: if (commit) state_d = (hold == 8'h5A) ? ARMED : IDLE;
                ARMED: begin
                    if (commit_zero) begin
                        state_d   = IDLE;
                        wr_seen_d = 1'b0;
                    end else if (web) begin
                        wr_seen_d = 1'b1;
                    end else if (wr_seen && !memwr) begin
                        state_d   = BUSY;
                        cnt_d     = BUSY_LOAD;
                        wr_seen_d = 1'b0;
                    end
                end
                BUSY: begin
                    // A lock request is remembered and honoured only once the window expires.
                    if (commit_zero) lock_pend_d = 1'b1;
                    if (cnt == 16'd0) begin
                        state_d     = (lock_pend || commit_zero) ? IDLE : ARMED;
                        lock_pend_d = 1'b0;
                    end else begin
                        cnt_d = cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    assign rom01cs_b  = RESET | ~((rd | web) & ~idx[1]);
    assign rom23cs_b  = RESET | ~((rd | web) & idx[1]);
    assign skt01p27   = RESET | ~(web & ~idx[1]);
    assign skt23p27   = RESET | ~(web & idx[1]);
    assign romoe_b    = RESET | ~rd;
    assign romdis_pre = ~RESET & rd;
    assign roma14     = ~RESET & idx[0];
    assign prog_busy  = ~RESET & (state == BUSY);

endmodule

// File: tb/tb_fourrom_ctrl.sv
// Self-checking bench for fourrom_ctrl: table-driven read decode, randomized reads
// against a select/unlock model, and hand sequences for programming and aborts.
module tb_fourrom_ctrl;
    localparam int PBC = 20;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] dip;
    logic [2:0] A;
    logic [7:0] D;
    logic       MREQ_B, IOREQ_B, RD_B, WR_B, ROMEN_B;
    logic       rom01cs_b, rom23cs_b, roma14, romoe_b, romdis_pre;
    logic       skt01p27, skt23p27, prog_busy;
    logic [7:0] outs;

    fourrom_ctrl #(.PROG_BUSY_CYCLES(PBC)) dut (
        .CLK(CLK), .RESET(RESET), .dip(dip), .A(A), .D(D),
        .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B), .ROMEN_B(ROMEN_B),
        .rom01cs_b(rom01cs_b), .rom23cs_b(rom23cs_b), .roma14(roma14), .romoe_b(romoe_b),
        .romdis_pre(romdis_pre), .skt01p27(skt01p27), .skt23p27(skt23p27),
        .prog_busy(prog_busy)
    );

    always #5 CLK = ~CLK;

    assign outs = {rom01cs_b, rom23cs_b, roma14, romoe_b, romdis_pre, skt01p27, skt23p27, prog_busy};

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: last committed select, unlock progress (0 locked, 1 key seen, 2 armed).
    logic [7:0] model_sel;
    int         model_stage;
    bit         model_busy;
    bit         model_lock;

    int run_len  = 0;
    int last_run = 0;
    always @(negedge CLK) begin
        if (prog_busy === 1'b1) run_len = run_len + 1;
        else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    typedef struct {
        logic [7:0] dip;
        logic [7:0] sel;
        logic [2:0] a;
        logic       romen_b;
        logic       rd_b;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [7:0] sel, input logic [7:0] d);
        return d[6] && (sel[7:2] == d[5:0]);
    endfunction

    // Expected {cs01, cs23, a14, oe, romdis, web01, web23, busy} from the board's rules.
    function automatic logic [7:0] model_out(input logic [7:0] sel, input logic [7:0] d,
                                             input logic [2:0] a, input logic romen_b,
                                             input logic rd_b, input logic mreq_b,
                                             input logic wr_b, input bit can_prog,
                                             input bit busy);
        bit rd, wr;
        logic [7:0] o;
        rd = model_hit(sel, d) && !romen_b && !rd_b && a[2] && a[1];
        wr = can_prog && model_hit(sel, d) && !mreq_b && !wr_b && a[2] && a[1] && !rd;
        o  = {1'b1, 1'b1, sel[0], !rd, rd, 1'b1, 1'b1, busy};
        if (rd || wr) begin
            if (sel[1]) o[6] = 1'b0;
            else        o[7] = 1'b0;
        end
        if (wr) begin
            if (sel[1]) o[1] = 1'b0;
            else        o[2] = 1'b0;
        end
        return o;
    endfunction

    task automatic model_reset();
        model_sel   = 8'h00;
        model_stage = 0;
        model_busy  = 0;
        model_lock  = 0;
    endtask

    task automatic model_commit(input logic [7:0] v);
        model_sel = v;
        if (!dip[7]) model_stage = 0;
        else if (model_busy) begin
            if (v == 8'h00) model_lock = 1;
        end else begin
            case (model_stage)
                0: if (v == 8'hA5) model_stage = 1;
                1: model_stage = (v == 8'h5A) ? 2 : 0;
                default: if (v == 8'h00) model_stage = 0;
            endcase
        end
    endtask

    task automatic bus_idle();
        MREQ_B = 1'b1; IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1; ROMEN_B = 1'b1;
        A = 3'b000; D = 8'h00;
    endtask

    task automatic io_write(input logic [7:0] v);
        @(negedge CLK);
        IOREQ_B = 1'b0; WR_B = 1'b0; A = 3'b110; D = v;
        @(negedge CLK);
        bus_idle();
        @(negedge CLK);
        model_commit(v);
    endtask

    task automatic mem_write(input string name);
        logic [7:0] exp;
        bit pulse;
        @(negedge CLK);
        MREQ_B = 1'b0; WR_B = 1'b0; A = 3'b110;
        #2;
        pulse = (model_stage == 2) && !model_busy && model_hit(model_sel, dip);
        exp   = model_out(model_sel, dip, A, 1'b1, 1'b1, 1'b0, 1'b0,
                          (model_stage == 2) && !model_busy, model_busy);
        check(name, outs, exp);
        @(negedge CLK);
        @(negedge CLK);
        bus_idle();
        if (pulse) begin
            model_busy = 1;
            last_run   = 0;
        end
    endtask

    task automatic wait_busy_end(input string name);
        int n = 0;
        @(negedge CLK);
        while (prog_busy === 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        #1;
        check(name, last_run, PBC);
        model_busy  = 0;
        model_stage = model_lock ? 0 : 2;
        model_lock  = 0;
    endtask

    task automatic read_check(input string name, input logic [7:0] exp);
        @(negedge CLK);
        A = 3'b110; MREQ_B = 1'b0; RD_B = 1'b0; ROMEN_B = 1'b0;
        #2;
        check(name, outs, exp);
        bus_idle();
    endtask

    logic [7:0] r_sel, r_dip;
    logic [2:0] r_a;
    logic       r_romen, r_rd;

    initial begin
        vecs[0] = '{8'h41, 8'h06, 3'b110, 1'b0, 1'b0, 8'h8E};
        vecs[1] = '{8'h41, 8'h03, 3'b110, 1'b0, 1'b0, 8'hF6};
        vecs[2] = '{8'h41, 8'h05, 3'b110, 1'b0, 1'b0, 8'h6E};
        vecs[3] = '{8'h41, 8'h05, 3'b110, 1'b1, 1'b0, 8'hF6};
        vecs[4] = '{8'h41, 8'h05, 3'b110, 1'b0, 1'b1, 8'hF6};
        vecs[5] = '{8'h41, 8'h05, 3'b100, 1'b0, 1'b0, 8'hF6};
        vecs[6] = '{8'h01, 8'h04, 3'b110, 1'b0, 1'b0, 8'hD6};
        vecs[7] = '{8'h7F, 8'hFF, 3'b111, 1'b0, 1'b0, 8'hAE};
        vecs[8] = '{8'h40, 8'h00, 3'b110, 1'b0, 1'b0, 8'h4E};
        vecs[9] = '{8'h7F, 8'hFC, 3'b011, 1'b0, 1'b0, 8'hD6};

        bus_idle();
        dip   = 8'h00;
        RESET = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        dip = 8'h40; A = 3'b110; MREQ_B = 1'b0; RD_B = 1'b0; ROMEN_B = 1'b0;
        #2;
        check("reset_outs", outs, 8'hD6);
        bus_idle();
        @(negedge CLK);
        RESET = 1'b0;

        // Read decode vectors.
        for (int i = 0; i < 10; i++) begin
            dip = vecs[i].dip;
            io_write(vecs[i].sel);
            @(negedge CLK);
            A = vecs[i].a; MREQ_B = 1'b0; ROMEN_B = vecs[i].romen_b; RD_B = vecs[i].rd_b;
            #2;
            check($sformatf("vec%0d", i), outs, vecs[i].exp);
            bus_idle();
        end

        // Randomized selects and reads against the model.
        for (int i = 0; i < 150; i++) begin
            r_sel = 8'($urandom);
            r_dip = {1'b0, 1'($urandom), 6'($urandom)};
            if ($urandom_range(0, 1) == 1) r_dip[5:0] = r_sel[7:2];
            dip = r_dip;
            io_write(r_sel);
            r_a     = 3'($urandom);
            r_romen = ($urandom_range(0, 3) == 0);
            r_rd    = ($urandom_range(0, 3) == 0);
            @(negedge CLK);
            A = r_a; MREQ_B = 1'b0; ROMEN_B = r_romen; RD_B = r_rd;
            #2;
            check("rand_read", outs, model_out(model_sel, dip, r_a, r_romen, r_rd,
                                               1'b0, 1'b1, 0, 0));
            bus_idle();
        end

        // Unlock, program socket 0/1, busy window, rearm, write during busy, lock in busy.
        dip = 8'hC0;
        io_write(8'hA5);
        io_write(8'h5A);
        io_write(8'h01);
        mem_write("prog_strobe");
        wait_busy_end("busy_len");
        mem_write("rearmed_strobe");
        mem_write("busy_strobe");
        io_write(8'h00);
        wait_busy_end("busy_len_locked");
        mem_write("locked_strobe");

        // Broken key sequence stays locked; the proper one arms socket 2/3.
        dip = 8'hD6;
        io_write(8'hA5);
        io_write(8'h12);
        io_write(8'h5A);
        mem_write("bad_key_strobe");
        io_write(8'hA5);
        io_write(8'h5A);
        mem_write("good_key_strobe");
        wait_busy_end("busy_len_23");

        // Program enable dropped mid-busy.
        mem_write("pre_drop_strobe");
        repeat (3) @(negedge CLK);
        #2;
        check("busy_before_drop", prog_busy, 1'b1);
        dip = 8'h56;
        @(negedge CLK);
        #2;
        check("busy_after_drop", prog_busy, 1'b0);
        model_busy = 0; model_stage = 0; model_lock = 0;
        dip = 8'hD6;
        mem_write("after_drop_strobe");

        // Reset mid-busy.
        io_write(8'hA5);
        io_write(8'h5A);
        mem_write("pre_reset_strobe");
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("busy_in_reset", prog_busy, 1'b0);
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        dip = 8'h40;
        read_check("romsel_cleared", 8'h4E);

        // Reset in the middle of a write strobe.
        dip = 8'hC0;
        io_write(8'hA5);
        io_write(8'h5A);
        io_write(8'h01);
        @(negedge CLK);
        MREQ_B = 1'b0; WR_B = 1'b0; A = 3'b110;
        #2;
        check("web_before_reset", skt01p27, 1'b0);
        RESET = 1'b1;
        #1;
        check("outs_reset_mid_write", outs, 8'hD6);
        model_reset();
        @(negedge CLK);
        bus_idle();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        #2;
        check("no_busy_after_abort", prog_busy, 1'b0);
        mem_write("post_reset_strobe");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fourrom_ctrl.md
FOURROM_CTRL -- requirements
Module: fourrom_ctrl

Interface
REQ-001 SHALL have parameter PROG_BUSY_CYCLES, default 40000: CLK cycles of the EEPROM write-busy window (10 ms at 4 MHz); legal range 2..65535.
REQ-002 SHALL have port CLK, input, 1 bit: CPC CPU clock; the only clock.
REQ-003 SHALL have port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port dip, input, 8 bits: [5:0] base-slot bits, [6] board enable, [7] program enable.
REQ-005 SHALL have port A, input, 3 bits: bus address A15..A13.
REQ-006 SHALL have port D, input, 8 bits: bus data; the block never drives it.
REQ-007 SHALL have ports MREQ_B, IOREQ_B, RD_B, WR_B and ROMEN_B, each input, 1 bit, active-low CPC bus strobes.
REQ-008 SHALL have ports rom01cs_b and rom23cs_b, each output, 1 bit: active-low chip selects for socket 0/1 and socket 2/3.
REQ-009 SHALL have port roma14, output, 1 bit: EEPROM A14 (ROM half within the socket).
REQ-010 SHALL have port romoe_b, output, 1 bit: active-low EEPROM output enable.
REQ-011 SHALL have port romdis_pre, output, 1 bit: active-high ROMDIS request, driven before the diode.
REQ-012 SHALL have ports skt01p27 and skt23p27, each output, 1 bit: active-low EEPROM write enables.
REQ-013 SHALL have port prog_busy, output, 1 bit: high during the write-busy window.

Function
REQ-014 SHALL define iowr = ~IOREQ_B & ~WR_B & ~A[13] and memwr = ~MREQ_B & ~WR_B & A[15] & A[14], both sampled on CLK rising edges.
REQ-015 SHALL capture D into a holding register on every CLK edge where iowr=1.
REQ-016 SHALL, on the first edge where iowr=0 after iowr=1, copy the holding register to romsel[7:0] (commit); the new value SHALL take effect one cycle after commit.
REQ-017 SHALL assert hit = dip[6] & (romsel[7:2] == dip[5:0]) and take idx = romsel[1:0].
REQ-018 SHALL drive roma14 = idx[0] at all times.
REQ-019 SHALL make read decode combinational from registered state: rd = hit & ~ROMEN_B & ~RD_B & A[15] & A[14].
REQ-020 SHALL, when rd=1, drive romoe_b=0 and romdis_pre=1; rom01cs_b=0 if idx[1]=0, otherwise rom23cs_b=0.
REQ-021 SHALL, when rd=0 and no write strobe is active, drive romoe_b, rom01cs_b and rom23cs_b high and romdis_pre low.
REQ-022 SHALL use a program-unlock FSM with states IDLE, KEY1, ARMED, BUSY.
REQ-023 SHALL make these FSM transitions on commit:
- IDLE: value 0xA5 -> KEY1.
- KEY1: value 0x5A -> ARMED; any other value -> IDLE.
- ARMED: value 0x00 -> IDLE; any other value stays ARMED and is the target select.
REQ-024 SHALL force the FSM to IDLE whenever dip[7]=0, including from BUSY, and clear the counter.
REQ-025 SHALL still latch the unlock key values into romsel as ordinary selects.
REQ-026 SHALL, in ARMED with hit=1 and memwr=1, drive the selected socket's skt*p27 low and its cs_b low for the duration of memwr, combinationally; romoe_b SHALL stay high.
REQ-027 SHALL, on the first edge after memwr falls while in ARMED, enter BUSY and load the counter with PROG_BUSY_CYCLES-1 (16-bit counter).
REQ-028 SHALL, in BUSY, decrement the counter each cycle, ignore memwr (skt*p27 stays high), keep read decode active, and hold prog_busy=1.
REQ-029 SHALL, when the counter is 0 in BUSY, return to ARMED on the next edge.
REQ-030 SHALL, in BUSY, latch a commit of 0x00 into romsel but not leave BUSY until the counter expires, then go to IDLE instead of ARMED.
REQ-031 SHALL never assert skt01p27 and skt23p27 together, and never assert either while rd=1.

Reset
REQ-032 SHALL, while RESET=1, force romsel=0x00, holding register=0x00, FSM=IDLE, counter=0, and the pending-lock flag clear.
REQ-033 SHALL, while RESET=1, drive these outputs: cs_b, oe, skt*p27 = 1; roma14, romdis_pre, prog_busy = 0.
REQ-034 SHALL, if RESET is asserted mid-BUSY or mid-write, abort immediately with no further web pulse.

Verification
REQ-035 SHALL cover: dip=0x41 (base slot 4, board enabled); IO write 0x06 to &DFxx; then read at &C000 with ROMEN_B=0 -> rom23cs_b=0, roma14=0, romoe_b=0, romdis_pre=1.
REQ-036 SHALL cover: select 0x03 with dip=0x41 -> no hit; read &C000 -> all selects high, romdis_pre=0.
REQ-037 SHALL cover: dip=0xC0; commits 0xA5, 0x5A, 0x01; memwr at &C123 -> skt01p27=0 and rom01cs_b=0 during the strobe; then prog_busy=1 for exactly PROG_BUSY_CYCLES cycles; FSM back in ARMED.
REQ-038 SHALL cover: a second memwr during BUSY -> no skt*p27 pulse; a commit of 0x00 during BUSY -> IDLE once the counter expires.
REQ-039 SHALL cover: commits 0xA5, 0x12, 0x5A -> FSM IDLE; subsequent memwr produces no web pulse.
REQ-040 SHALL cover: dip[7] dropped, or RESET pulsed, mid-BUSY -> prog_busy=0 next cycle (immediately for RESET), FSM IDLE, romsel=0 after reset.
